// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the 32-bit Fibonacci LFSR stream
// (taps 31, 29, 25, 24; shift left, feedback into bit 0). It seeds itself
// from the first 32 valid bits, then predicts every following bit, counts
// mismatches, and falls back to re-seeding when one window holds too many
// errors.
module prbs_checker #(
    parameter int ERR_THRESH = 4,
    parameter int WINDOW     = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             seed_fail,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W = $clog2(ERR_THRESH + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] THRESH   = WERR_W'(ERR_THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        s_q, s_d;
    logic [4:0]         seed_cnt_q, seed_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic               err_pulse_q, err_pulse_d;
    logic               seed_fail_q, seed_fail_d;
    logic               locked_q, locked_d;

    logic               pred;
    logic               mismatch;
    logic               bit_inc;
    logic [WERR_W-1:0]  win_err_upd;

    // Next-state logic: seeding, bit prediction, window bookkeeping, counters.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        seed_cnt_d  = seed_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        seed_fail_d = 1'b0;
        mismatch    = 1'b0;
        bit_inc     = 1'b0;
        win_err_upd = win_err_q;

        pred = s_q[31] ^ s_q[29] ^ s_q[25] ^ s_q[24];

        if (bit_valid) begin
            if (state_q == SEED) begin
                s_d = {s_q[30:0], bit_in};
                if (seed_cnt_q == 5'd31) begin
                    seed_cnt_d = '0;
                    if (s_d != '0) begin
                        state_d   = CHECK;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        // An all-zero register would predict zeros forever.
                        seed_fail_d = 1'b1;
                    end
                end else begin
                    seed_cnt_d = seed_cnt_q + 5'd1;
                end
            end else begin
                // Shift in the prediction, not the received bit, so a single
                // line error costs exactly one mismatch.
                s_d         = {s_q[30:0], pred};
                bit_inc     = 1'b1;
                mismatch    = bit_in ^ pred;
                err_pulse_d = mismatch;
                win_err_upd = win_err_q + WERR_W'(mismatch);
                if (win_err_upd >= THRESH) begin
                    // Loss of lock wins over the window wrap on the same bit.
                    state_d    = SEED;
                    seed_cnt_d = '0;
                    win_cnt_d  = '0;
                    win_err_d  = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    win_err_d = win_err_upd;
                end
            end
        end

        locked_d = (state_d == CHECK);

        err_count_d = err_count_q;
        if (clear)
            err_count_d = '0;
        else if (mismatch && (err_count_q != CNT_MAX))
            err_count_d = err_count_q + CNT_W'(1);

        bit_count_d = bit_count_q;
        if (clear)
            bit_count_d = '0;
        else if (bit_inc && (bit_count_q != CNT_MAX))
            bit_count_d = bit_count_q + CNT_W'(1);
    end

    // State register with asynchronous return to an empty, unlocked checker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEED;
            s_q         <= '0;
            seed_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            bit_count_q <= '0;
            err_pulse_q <= 1'b0;
            seed_fail_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            seed_cnt_q  <= seed_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
            err_pulse_q <= err_pulse_d;
            seed_fail_q <= seed_fail_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign seed_fail = seed_fail_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (16-bit and 4-bit counters) share one
// input stream; a sequence-level model predicts every output after each edge.
module tb_prbs_checker;

    localparam int THR = 4;
    localparam int WIN = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clear = 1'b0;

    logic        la, epa, sfa;
    logic [15:0] eca, bca;
    logic        lb, epb, sfb;
    logic [3:0]  ecb, bcb;

    int checks = 0;
    int failures = 0;

    prbs_checker #(.ERR_THRESH(THR), .WINDOW(WIN), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .locked(la), .err_pulse(epa), .seed_fail(sfa),
        .err_count(eca), .bit_count(bca)
    );

    prbs_checker #(.ERR_THRESH(THR), .WINDOW(WIN), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .locked(lb), .err_pulse(epb), .seed_fail(sfb),
        .err_count(ecb), .bit_count(bcb)
    );

    always #5 clk = ~clk;

    // Reference model: the last 32 bits of the reference sequence
    // (hist[0] oldest). Next bit x[n] = x[n-32]^x[n-30]^x[n-26]^x[n-25].
    bit hist[$];
    bit m_locked, m_ep, m_sf;
    int m_seed_n, m_wcnt, m_werr;
    int m_eca, m_bca, m_ecb, m_bcb;

    function automatic bit m_pred();
        return hist[0] ^ hist[2] ^ hist[6] ^ hist[7];
    endfunction

    function automatic int sat_inc(int v, int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 32; i++) hist.push_back(1'b0);
        m_locked = 0; m_ep = 0; m_sf = 0;
        m_seed_n = 0; m_wcnt = 0; m_werr = 0;
        m_eca = 0; m_bca = 0; m_ecb = 0; m_bcb = 0;
    endtask

    task automatic model_step(input bit b, input bit v, input bit clr);
        bit e, counted, p, any_one;
        e = 0; counted = 0;
        m_ep = 0; m_sf = 0;
        if (v) begin
            if (!m_locked) begin
                hist.push_back(b);
                void'(hist.pop_front());
                m_seed_n++;
                if (m_seed_n == 32) begin
                    m_seed_n = 0;
                    any_one = 0;
                    foreach (hist[i]) any_one |= hist[i];
                    if (!any_one) m_sf = 1;
                    else begin m_locked = 1; m_wcnt = 0; m_werr = 0; end
                end
            end else begin
                p = m_pred();
                hist.push_back(p);
                void'(hist.pop_front());
                counted = 1;
                if (b != p) begin e = 1; m_ep = 1; m_werr++; end
                if (m_werr >= THR) begin
                    m_locked = 0; m_seed_n = 0; m_wcnt = 0; m_werr = 0;
                end else if (m_wcnt == WIN - 1) begin
                    m_wcnt = 0; m_werr = 0;
                end else begin
                    m_wcnt++;
                end
            end
        end
        if (clr) begin
            m_eca = 0; m_bca = 0; m_ecb = 0; m_bcb = 0;
        end else begin
            if (e)       begin m_eca = sat_inc(m_eca, 65535); m_ecb = sat_inc(m_ecb, 15); end
            if (counted) begin m_bca = sat_inc(m_bca, 65535); m_bcb = sat_inc(m_bcb, 15); end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("locked_a", {31'd0, la}, {31'd0, m_locked});
        chk("err_pulse_a", {31'd0, epa}, {31'd0, m_ep});
        chk("seed_fail_a", {31'd0, sfa}, {31'd0, m_sf});
        chk("err_count_a", {16'd0, eca}, m_eca);
        chk("bit_count_a", {16'd0, bca}, m_bca);
        chk("locked_b", {31'd0, lb}, {31'd0, m_locked});
        chk("err_pulse_b", {31'd0, epb}, {31'd0, m_ep});
        chk("err_count_b", {28'd0, ecb}, m_ecb);
        chk("bit_count_b", {28'd0, bcb}, m_bcb);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"}, {31'd0, la | lb}, 32'd0);
        chk({tag, "_pulses"}, {30'd0, epa | epb, sfa | sfb}, 32'd0);
        chk({tag, "_counts"}, {eca | bca, 8'd0, ecb | bcb}, 32'd0);
    endtask

    // One clock: drive, let the edge sample, update the model, compare.
    task automatic step(input bit b, input bit v, input bit clr);
        bit_in = b; bit_valid = v; clear = clr;
        @(posedge clk);
        model_step(b, v, clr);
        #1;
        check_all();
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) step(m_pred(), 1'b1, 1'b0);
    endtask

    task automatic bad();
        step(~m_pred(), 1'b1, 1'b0);
    endtask

    task automatic seed_const(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        bit_valid = 0; clear = 0;
        reset = 1;
        #2;
        model_reset();
        check_zero(tag);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        bit b, v, c;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset("reset0");

        // Lock on all ones, then 24 zeros all match the prediction.
        seed_const(1'b1, 31);
        chk("pre_lock", {31'd0, la}, 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("lock_ones", {31'd0, la}, 32'd1);
        seed_const(1'b0, 24);
        chk("zeros_err", {16'd0, eca}, 32'd0);
        chk("zeros_bits", {16'd0, bca}, 32'd24);

        // A single flipped bit costs exactly one error.
        do_reset("reset1");
        seed_const(1'b1, 32);
        step(1'b1, 1'b1, 1'b0);
        chk("one_err_pulse", {31'd0, epa}, 32'd1);
        seed_const(1'b0, 23);
        chk("one_err_count", {16'd0, eca}, 32'd1);
        chk("one_err_locked", {31'd0, la}, 32'd1);

        // All-zero seed is rejected, then a good seed locks.
        do_reset("reset2");
        seed_const(1'b0, 32);
        chk("seed_fail", {31'd0, sfa}, 32'd1);
        chk("seed_fail_unlocked", {31'd0, la}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("seed_fail_once", {31'd0, sfa}, 32'd0);
        seed_const(1'b1, 32);
        chk("relock_after_fail", {31'd0, la}, 32'd1);

        // Four errors inside a window drop lock; 32 bits later it relocks.
        do_reset("reset3");
        seed_const(1'b1, 32);
        for (int k = 0; k < 4; k++) begin good(4); bad(); end
        chk("thresh_unlock", {31'd0, la}, 32'd0);
        chk("thresh_count", {16'd0, eca}, 32'd4);
        for (int i = 0; i < 31; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        chk("reseed_wait", {31'd0, la}, 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("reseed_lock", {31'd0, la}, 32'd1);

        // Three errors per window across three windows keep lock.
        do_reset("reset4");
        seed_const(1'b1, 32);
        for (int w = 0; w < 3; w++) begin
            good(10); bad(); good(9); bad(); good(9); bad(); good(33);
        end
        chk("window_locked", {31'd0, la}, 32'd1);
        chk("window_count", {16'd0, eca}, 32'd9);

        // Saturation of the narrow counters, then clear beating an increment.
        do_reset("reset5");
        seed_const(1'b1, 32);
        for (int k = 0; k < 20; k++) begin bad(); good(63); end
        chk("sat_wide", {16'd0, eca}, 32'd20);
        chk("sat_narrow", {28'd0, ecb}, 32'd15);
        chk("sat_narrow_bits", {28'd0, bcb}, 32'd15);
        step(~m_pred(), 1'b1, 1'b1);
        chk("clear_err", {28'd0, ecb}, 32'd0);
        chk("clear_pulse", {31'd0, epb}, 32'd1);
        chk("clear_keeps_lock", {31'd0, lb}, 32'd1);

        // Randomized traffic: gaps, clears, sparse errors, zero-seed bursts.
        do_reset("reset6");
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 63) == 0);
            if (m_locked) b = m_pred() ^ ($urandom_range(0, 11) == 0);
            else if (((i / 150) % 4) == 3) b = 1'b0;
            else b = 1'($urandom_range(0, 1));
            step(b, v, c);
        end

        // Asynchronous reset in the middle of checking.
        if (!m_locked) seed_const(1'b1, 32);
        good(5); bad(); good(3);
        bit_valid = 1; bit_in = m_pred();
        #2;
        reset = 1;
        #1;
        model_reset();
        check_zero("async_reset");
        @(negedge clk);
        reset = 0;
        bit_valid = 0;
        step(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
